// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Default widths, address/data word types and the hardwired-zero address.
package regfile_pkg;

   localparam int unsigned XLEN_DEF  = 8;
   localparam int unsigned NREG_DEF  = 8;
   localparam int unsigned AW_DEF    = $clog2(NREG_DEF);
   localparam int unsigned ZERO_ADDR = 0;

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] data_word_t;

   // True when addr names the hardwired-zero register of a ZERO_REG build.
   function automatic logic is_zero_addr(input logic zero_en, input int unsigned addr);
      return zero_en && (addr == ZERO_ADDR);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, issue wins on collision.
// With REGFILE_SB_BYPASS_EN, a same-cycle writeback hides the busy bit on the read ports.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter  int unsigned NREG     = NREG_DEF,
   parameter  int unsigned ZERO_REG = 1,
   localparam int unsigned AW       = $clog2(NREG)
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            ISSUE,
   input  logic [AW-1:0]   ISSUE_DR,
   input  logic            LD,
   input  logic [AW-1:0]   DR,
   input  logic [AW-1:0]   SA,
   input  logic [AW-1:0]   SB,
   output logic [NREG-1:0] busy_vec,
   output logic            busy_a,
   output logic            busy_b
);

   localparam logic HAS_ZERO = (ZERO_REG != 0);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_nxt;

   // Next-state: issue beats writeback; register 0 never becomes busy.
   always_comb begin
      busy_nxt = busy_q;
      for (int i = 0; i < NREG; i++) begin
         if (ISSUE && (ISSUE_DR == AW'(i))) begin
            busy_nxt[i] = 1'b1;
         end else if (LD && (DR == AW'(i))) begin
            busy_nxt[i] = 1'b0;
         end
         if (is_zero_addr(HAS_ZERO, i)) begin
            busy_nxt[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_nxt;
      end
   end

   assign busy_vec = busy_q;

   // Read-port busy lookup.
   always_comb begin
      busy_a = busy_q[SA];
      busy_b = busy_q[SB];
`ifdef REGFILE_SB_BYPASS_EN
      if (LD && (DR == SA) && !(ISSUE && (ISSUE_DR == SA))) begin
         busy_a = 1'b0;
      end
      if (LD && (DR == SB) && !(ISSUE && (ISSUE_DR == SB))) begin
         busy_b = 1'b0;
      end
`endif
   end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised 2R/1W register file with optional hardwired-zero r0 and a busy-bit scoreboard.
// Define REGFILE_SB_BYPASS_EN for same-cycle write-through forwarding on both read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int unsigned XLEN     = XLEN_DEF,
   parameter  int unsigned NREG     = NREG_DEF,
   parameter  int unsigned ZERO_REG = 1,
   localparam int unsigned AW       = $clog2(NREG)
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [AW-1:0]   SA,
   input  logic [AW-1:0]   SB,
   output logic [XLEN-1:0] DataA,
   output logic [XLEN-1:0] DataB,
   output logic            BusyA,
   output logic            BusyB,
   input  logic            LD,
   input  logic [AW-1:0]   DR,
   input  logic [XLEN-1:0] D_in,
   input  logic            ISSUE,
   input  logic [AW-1:0]   ISSUE_DR,
   output logic [NREG-1:0] BUSY_VEC
);

   localparam logic HAS_ZERO = (ZERO_REG != 0);

   logic [XLEN-1:0] mem [NREG];
   logic            wr_en;
   logic            sa_zero;
   logic            sb_zero;

   assign wr_en   = LD && !(HAS_ZERO && (DR == AW'(ZERO_ADDR)));
   assign sa_zero = HAS_ZERO && (SA == AW'(ZERO_ADDR));
   assign sb_zero = HAS_ZERO && (SB == AW'(ZERO_ADDR));

   // Storage: reset clears every word, writes to r0 are dropped when hardwired.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[DR] <= D_in;
      end
   end

   // Asynchronous read muxes.
   always_comb begin
      DataA = mem[SA];
      DataB = mem[SB];
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_en && (DR == SA)) begin
         DataA = D_in;
      end
      if (wr_en && (DR == SB)) begin
         DataB = D_in;
      end
`endif
      if (sa_zero) begin
         DataA = '0;
      end
      if (sb_zero) begin
         DataB = '0;
      end
   end

   rf_scoreboard #(
      .NREG     (NREG),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .CLK      (CLK),
      .RESET    (RESET),
      .ISSUE    (ISSUE),
      .ISSUE_DR (ISSUE_DR),
      .LD       (LD),
      .DR       (DR),
      .SA       (SA),
      .SB       (SB),
      .busy_vec (BUSY_VEC),
      .busy_a   (BusyA),
      .busy_b   (BusyB)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (XLEN=8, NREG=8, ZERO_REG=1); expectations follow REGFILE_SB_BYPASS_EN.
module tb_regfile_sb;

   logic       CLK;
   logic       RESET;
   logic [2:0] SA, SB, DR, ISSUE_DR;
   logic [7:0] DataA, DataB, D_in, BUSY_VEC;
   logic       BusyA, BusyB, LD, ISSUE;

   int vectors     = 0;
   int miscompares = 0;

`ifdef REGFILE_SB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   regfile_sb dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .SA       (SA),
      .SB       (SB),
      .DataA    (DataA),
      .DataB    (DataB),
      .BusyA    (BusyA),
      .BusyB    (BusyB),
      .LD       (LD),
      .DR       (DR),
      .D_in     (D_in),
      .ISSUE    (ISSUE),
      .ISSUE_DR (ISSUE_DR),
      .BUSY_VEC (BUSY_VEC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      RESET = 1'b1; LD = 1'b0; ISSUE = 1'b0;
      SA = 3'd3; SB = 3'd5; DR = 3'd0; ISSUE_DR = 3'd0; D_in = 8'h00;
      tick();
      RESET = 1'b0;
      #1;
      chk("rst_dataa", DataA, 8'h00);
      chk("rst_datab", DataB, 8'h00);
      chk("rst_busya", BusyA, 1'b0);
      chk("rst_busyb", BusyB, 1'b0);
      chk("rst_busyvec", BUSY_VEC, 8'h00);

      // Write r4, check same-cycle then next-cycle read
      LD = 1'b1; DR = 3'd4; D_in = 8'hA5; SA = 3'd4;
      #1;
      chk("wr_same_cycle", DataA, BYP ? 8'hA5 : 8'h00);
      tick();
      LD = 1'b0;
      #1;
      chk("wr_next_cycle", DataA, 8'hA5);
      chk("wr_other_port", DataB, 8'h00);

      // Zero register: write and issue both ignored
      LD = 1'b1; DR = 3'd0; D_in = 8'hFF; ISSUE = 1'b1; ISSUE_DR = 3'd0; SA = 3'd0;
      #1;
      chk("zero_same_cycle", DataA, 8'h00);
      tick();
      LD = 1'b0; ISSUE = 1'b0;
      #1;
      chk("zero_dataa", DataA, 8'h00);
      chk("zero_busya", BusyA, 1'b0);
      chk("zero_busyvec", BUSY_VEC, 8'h00);

      // Scoreboard lifecycle on r2
      ISSUE = 1'b1; ISSUE_DR = 3'd2;
      tick();
      ISSUE = 1'b0; SA = 3'd2;
      #1;
      chk("sb_issue_vec", BUSY_VEC, 8'h04);
      chk("sb_issue_busya", BusyA, 1'b1);
      tick();
      tick();
      chk("sb_hold_vec", BUSY_VEC, 8'h04);
      LD = 1'b1; DR = 3'd2; D_in = 8'h3C;
      #1;
      chk("sb_wb_busya_same", BusyA, BYP ? 1'b0 : 1'b1);
      chk("sb_wb_dataa_same", DataA, BYP ? 8'h3C : 8'h00);
      tick();
      LD = 1'b0;
      #1;
      chk("sb_wb_vec", BUSY_VEC, 8'h00);
      chk("sb_wb_busya", BusyA, 1'b0);
      chk("sb_wb_dataa", DataA, 8'h3C);

      // Simultaneous issue r6 and writeback r1
      ISSUE = 1'b1; ISSUE_DR = 3'd6; LD = 1'b1; DR = 3'd1; D_in = 8'h77;
      tick();
      ISSUE = 1'b0; LD = 1'b0; SA = 3'd1;
      #1;
      chk("dual_vec", BUSY_VEC, 8'h40);
      chk("dual_data", DataA, 8'h77);

      // Collision on busy r6: issue wins, data still written
      ISSUE = 1'b1; ISSUE_DR = 3'd6; LD = 1'b1; DR = 3'd6; D_in = 8'h11; SB = 3'd6;
      #1;
      chk("coll_busyb_same", BusyB, 1'b1);
      chk("coll_datab_same", DataB, BYP ? 8'h11 : 8'h00);
      tick();
      ISSUE = 1'b0; LD = 1'b0;
      #1;
      chk("coll_vec", BUSY_VEC, 8'h40);
      chk("coll_busyb", BusyB, 1'b1);
      chk("coll_datab", DataB, 8'h11);

      // Write-through candidate on r7
      LD = 1'b1; DR = 3'd7; D_in = 8'h5A; SB = 3'd7;
      #1;
      chk("byp_datab", DataB, BYP ? 8'h5A : 8'h00);
      chk("byp_busyb", BusyB, 1'b0);
      tick();
      LD = 1'b0;
      #1;
      chk("byp_datab_next", DataB, 8'h5A);

      // Busy r1, r3, r5 (r3 issued twice) then reset mid-operation
      ISSUE = 1'b1; ISSUE_DR = 3'd1; tick();
      ISSUE_DR = 3'd3; tick();
      ISSUE_DR = 3'd5; tick();
      ISSUE_DR = 3'd3; tick();
      ISSUE = 1'b0;
      #1;
      chk("multi_busy_vec", BUSY_VEC, 8'h6A);
      RESET = 1'b1; LD = 1'b1; DR = 3'd4; D_in = 8'hEE; ISSUE = 1'b1; ISSUE_DR = 3'd7;
      tick();
      RESET = 1'b0; LD = 1'b0; ISSUE = 1'b0;
      #1;
      chk("rst2_vec", BUSY_VEC, 8'h00);
      for (int i = 0; i < 8; i++) begin
         SA = 3'(i);
         SB = 3'(7 - i);
         #1;
         chk($sformatf("rst2_dataa_r%0d", i), DataA, 8'h00);
         chk($sformatf("rst2_datab_r%0d", 7 - i), DataB, 8'h00);
         chk($sformatf("rst2_busya_r%0d", i), BusyA, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
